// File: rtl/subframe_sequencer_if.sv
// Frame-control, decoder and PCM-output signal bundle around the subframe sequencer.
// slave = sequencer side, master = frame parser / decoder / PCM stage side.
interface subframe_sequencer_if;
    logic        iStart;
    logic [15:0] iBaseAddr;
    logic [3:0]  iNChannels;
    logic [15:0] iBlockSize;
    logic        oBusy;
    logic        oDone;

    logic        oDecReset;
    logic        oDecEnable;
    logic [19:0] oDecNSamples;
    logic        iDecSampleValid;
    logic        iDecFrameDone;
    logic [15:0] iDecSample;
    logic [15:0] iDecReadAddr;
    logic [15:0] oRamAddr;

    logic [15:0] oSample;
    logic [2:0]  oChannel;
    logic        oSampleValid;
    logic        iSampleReady;

    modport slave (
        input  iStart, iBaseAddr, iNChannels, iBlockSize,
        output oBusy, oDone,
        output oDecReset, oDecEnable, oDecNSamples, oRamAddr,
        input  iDecSampleValid, iDecFrameDone, iDecSample, iDecReadAddr,
        output oSample, oChannel, oSampleValid,
        input  iSampleReady
    );

    modport master (
        output iStart, iBaseAddr, iNChannels, iBlockSize,
        input  oBusy, oDone,
        input  oDecReset, oDecEnable, oDecNSamples, oRamAddr,
        output iDecSampleValid, iDecFrameDone, iDecSample, iDecReadAddr,
        input  oSample, oChannel, oSampleValid,
        output iSampleReady
    );
endinterface

// File: rtl/subframe_sequencer.sv
// Runs one subframe decode per channel, rebasing decoder RAM reads and tagging samples with channel.
// Sample -> oSampleValid in 1 cycle via FIFO; decoder enable withheld at STALL_LEVEL occupancy.
module subframe_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int STALL_LEVEL = 2
) (
    input  logic iClock,
    input  logic iReset,
    subframe_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, DRESET, RUN, NEXT, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   chan_base;
    logic [15:0]   max_addr;
    logic [15:0]   block_size;
    logic [2:0]    chan;
    logic [2:0]    nch_m1;
    logic [2:0]    nch_m1_in;

    logic [18:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;

    logic dec_reset, dec_en, busy, done;
    logic push, pop;

    // Zero channels is treated as one; anything beyond 8 clamps to the 3-bit tag range.
    always_comb begin
        nch_m1_in = 3'(bus.iNChannels - 4'd1);
        if (bus.iNChannels == 4'd0)
            nch_m1_in = 3'd0;
        else if (bus.iNChannels > 4'd8)
            nch_m1_in = 3'd7;
    end

    always_ff @(posedge iClock) begin
        if (iReset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dec_reset = 1'b1;
        dec_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.iStart)
                    state_nxt = DRESET;
            end
            DRESET: begin
                dec_en    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                dec_reset = 1'b0;
                dec_en    = (fifo_count < CW'(STALL_LEVEL));
                if (bus.iDecFrameDone && dec_en)
                    state_nxt = NEXT;
            end
            NEXT:    state_nxt = (chan == nch_m1) ? DRAIN : DRESET;
            DRAIN:   if (fifo_count == '0) state_nxt = DONE;
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            chan_base  <= '0;
            max_addr   <= '0;
            chan       <= '0;
            nch_m1     <= '0;
            block_size <= '0;
        end else begin
            case (state)
                IDLE: if (bus.iStart) begin
                    block_size <= bus.iBlockSize;
                    nch_m1     <= nch_m1_in;
                    chan_base  <= bus.iBaseAddr;
                    chan       <= '0;
                    max_addr   <= '0;
                end
                RUN: if (dec_en && (bus.iDecReadAddr > max_addr))
                    max_addr <= bus.iDecReadAddr;
                // Subframes are packed word-aligned, so the next one starts right after the last word read.
                NEXT: begin
                    chan_base <= chan_base + max_addr + 16'd1;
                    max_addr  <= '0;
                    if (chan != nch_m1)
                        chan <= chan + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign push = (state == RUN) && dec_en && bus.iDecSampleValid;
    assign pop  = (fifo_count != '0) && bus.iSampleReady;

    always_ff @(posedge iClock) begin
        if (push)
            fifo_mem[wr_ptr] <= {chan, bus.iDecSample};
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge iClock) disable iff (iReset)
        !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

    assign bus.oBusy        = busy;
    assign bus.oDone        = done;
    assign bus.oDecReset    = dec_reset;
    assign bus.oDecEnable   = dec_en;
    assign bus.oDecNSamples = {4'd0, block_size - 16'd1};
    assign bus.oRamAddr     = chan_base + bus.iDecReadAddr;
    assign bus.oSample      = fifo_mem[rd_ptr][15:0];
    assign bus.oChannel     = fifo_mem[rd_ptr][18:16];
    assign bus.oSampleValid = (fifo_count != '0);
endmodule

// File: tb/tb_subframe_sequencer.sv
// Bench for subframe_sequencer: behavioural decoder, address/sample scoreboards checked at negedge.
module tb_subframe_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    subframe_sequencer_if bus();

    subframe_sequencer #(.FIFO_DEPTH(4), .STALL_LEVEL(2)) dut (
        .iClock(clk),
        .iReset(rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_addr [$];
    logic [18:0] exp_smp  [$];

    int rd_n  [8];
    int smp_n [8];
    logic [3:0] test_id = 4'd0;
    int step     = 0;
    int drst_cnt = 0;
    int sub_off  = 0;
    int mcount   = 0;
    int done_cnt = 0;
    int dm_s, dm_r, dm_n, dm_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Decoder model: reads min(step, R-1), emits samples for step < S, frame ends at max(R,S)-1.
    always_comb begin
        dm_s = (drst_cnt - sub_off - 1) & 7;
        dm_r = rd_n[dm_s];
        dm_n = smp_n[dm_s];
        dm_t = (dm_r > dm_n) ? dm_r : dm_n;
        bus.iDecReadAddr    = 16'((step < dm_r) ? step : dm_r - 1);
        bus.iDecSampleValid = (step < dm_n);
        bus.iDecFrameDone   = (step == dm_t - 1);
        bus.iDecSample      = {test_id, 4'(dm_s), 8'(step)};
    end

    logic m_push, m_pop;
    assign m_push = bus.iDecSampleValid && bus.oDecEnable && !bus.oDecReset;
    assign m_pop  = bus.oSampleValid && bus.iSampleReady;

    always @(posedge clk) begin
        if (bus.oDecReset && bus.oDecEnable) drst_cnt <= drst_cnt + 1;
        if (bus.oDecReset)       step <= 0;
        else if (bus.oDecEnable) step <= step + 1;
        if (rst) mcount <= 0;
        else     mcount <= mcount + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.oDecEnable && !bus.oDecReset) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ram_addr: unexpected read 0x%0h, expected none", bus.oRamAddr);
                end else
                    check("ram_addr", 32'(bus.oRamAddr), 32'(exp_addr.pop_front()));
            end
            if (m_pop) begin
                if (exp_smp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sample: unexpected ch%0d 0x%0h, expected none", bus.oChannel, bus.oSample);
                end else
                    check("sample", 32'({bus.oChannel, bus.oSample}), 32'(exp_smp.pop_front()));
            end
            if (!bus.oDecReset)
                check("dec_enable_stall", 32'(bus.oDecEnable), 32'(mcount < 2));
            check("sample_valid", 32'(bus.oSampleValid), 32'(mcount != 0));
            if (bus.oDone) done_cnt++;
        end
    end

    task automatic start_frame(input logic [15:0] base, input logic [3:0] nch, input logic [15:0] bs);
        sub_off        = drst_cnt;
        bus.iBaseAddr  = base;
        bus.iNChannels = nch;
        bus.iBlockSize = bs;
        bus.iStart     = 1'b1;
        cyc(1);
        bus.iStart     = 1'b0;
        check("busy_after_start", 32'(bus.oBusy), 32'd1);
        check("dec_nsamples", 32'(bus.oDecNSamples), 32'(bs) - 32'd1);
    endtask

    task automatic wait_done(input string name, input int n_sub);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 2000) begin
            cyc(1);
            k++;
        end
        cyc(3);
        check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_busy_clear"}, 32'(bus.oBusy), 32'd0);
        check({name, "_dreset_pulses"}, 32'(drst_cnt - sub_off), 32'(n_sub));
        check({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        check({name, "_smp_left"}, 32'(exp_smp.size()), 32'd0);
    endtask

    initial begin
        int k;
        int d0;
        bus.iStart = 1'b0;
        bus.iBaseAddr = '0;
        bus.iNChannels = '0;
        bus.iBlockSize = '0;
        bus.iSampleReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_n[i] = 1;
            smp_n[i] = 0;
        end
        rst = 1'b1;
        cyc(3);
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_done", 32'(bus.oDone), 32'd0);
        check("rst_dec_reset", 32'(bus.oDecReset), 32'd1);
        check("rst_dec_enable", 32'(bus.oDecEnable), 32'd0);
        check("rst_sample_valid", 32'(bus.oSampleValid), 32'd0);
        rst = 1'b0;
        cyc(2);

        // 1 channel, base 0x100, reads 0..9, 4 samples
        test_id = 4'd1; rd_n[0] = 10; smp_n[0] = 4;
        for (int i = 0; i < 10; i++) exp_addr.push_back(16'h0100 + 16'(i));
        for (int i = 0; i < 4; i++)  exp_smp.push_back({3'd0, 16'h1000 + 16'(i)});
        start_frame(16'h0100, 4'd1, 16'd4);
        wait_done("one_ch", 1);

        // 2 channels, base 0x20; ch0 reads up to 5 so ch1 starts at 0x26
        test_id = 4'd2; rd_n[0] = 6; smp_n[0] = 3; rd_n[1] = 6; smp_n[1] = 3;
        for (int i = 0; i < 6; i++) exp_addr.push_back(16'h0020 + 16'(i));
        for (int i = 0; i < 6; i++) exp_addr.push_back(16'h0026 + 16'(i));
        for (int i = 0; i < 3; i++) exp_smp.push_back({3'd0, 16'h2000 + 16'(i)});
        for (int i = 0; i < 3; i++) exp_smp.push_back({3'd1, 16'h2100 + 16'(i)});
        start_frame(16'h0020, 4'd2, 16'd3);
        wait_done("two_ch", 2);

        // Downstream stalled: decoder must be held once two samples are queued
        test_id = 4'd3; rd_n[0] = 8; smp_n[0] = 8;
        for (int i = 0; i < 8; i++) exp_addr.push_back(16'h0400 + 16'(i));
        for (int i = 0; i < 8; i++) exp_smp.push_back({3'd0, 16'h3000 + 16'(i)});
        bus.iSampleReady = 1'b0;
        start_frame(16'h0400, 4'd1, 16'd8);
        cyc(20);
        check("stall_enable_low", 32'(bus.oDecEnable), 32'd0);
        check("stall_valid_high", 32'(bus.oSampleValid), 32'd1);
        check("stall_head", 32'({bus.oChannel, bus.oSample}), 32'({3'd0, 16'h3000}));
        bus.iSampleReady = 1'b1;
        wait_done("stall", 1);

        // Address wrap at 2^16
        test_id = 4'd4; rd_n[0] = 4; smp_n[0] = 2;
        exp_addr.push_back(16'hFFFE); exp_addr.push_back(16'hFFFF);
        exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
        exp_smp.push_back({3'd0, 16'h4000}); exp_smp.push_back({3'd0, 16'h4001});
        start_frame(16'hFFFE, 4'd1, 16'd2);
        wait_done("wrap", 1);

        // iNChannels=0 runs one channel; a second iStart mid-run changes nothing
        test_id = 4'd5; rd_n[0] = 3; smp_n[0] = 3;
        for (int i = 0; i < 3; i++) exp_addr.push_back(16'h0300 + 16'(i));
        for (int i = 0; i < 3; i++) exp_smp.push_back({3'd0, 16'h5000 + 16'(i)});
        start_frame(16'h0300, 4'd0, 16'd3);
        cyc(1);
        bus.iBaseAddr = 16'h0999; bus.iNChannels = 4'd4; bus.iBlockSize = 16'd9;
        bus.iStart = 1'b1;
        cyc(1);
        bus.iStart = 1'b0;
        wait_done("zero_nch", 1);
        check("config_kept_nsamples", 32'(bus.oDecNSamples), 32'd2);

        // Reset while channel 1 is running: abort without oDone
        test_id = 4'd6; rd_n[0] = 4; smp_n[0] = 4; rd_n[1] = 10; smp_n[1] = 10;
        for (int i = 0; i < 4; i++)  exp_addr.push_back(16'h0500 + 16'(i));
        for (int i = 0; i < 10; i++) exp_addr.push_back(16'h0504 + 16'(i));
        for (int i = 0; i < 4; i++)  exp_smp.push_back({3'd0, 16'h6000 + 16'(i)});
        for (int i = 0; i < 10; i++) exp_smp.push_back({3'd1, 16'h6100 + 16'(i)});
        start_frame(16'h0500, 4'd2, 16'd4);
        k = 0;
        while ((drst_cnt - sub_off) < 2 && k < 200) begin
            cyc(1);
            k++;
        end
        check("reset_reached_ch1", 32'(drst_cnt - sub_off), 32'd2);
        cyc(3);
        bus.iSampleReady = 1'b0;
        cyc(2);
        check("reset_pre_busy", 32'(bus.oBusy), 32'd1);
        check("reset_pre_valid", 32'(bus.oSampleValid), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        cyc(1);
        exp_addr.delete();
        exp_smp.delete();
        check("reset_busy", 32'(bus.oBusy), 32'd0);
        check("reset_sample_valid", 32'(bus.oSampleValid), 32'd0);
        check("reset_dec_reset", 32'(bus.oDecReset), 32'd1);
        rst = 1'b0;
        bus.iSampleReady = 1'b1;
        cyc(10);
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);
        check("reset_idle_busy", 32'(bus.oBusy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
